// File: rtl/stream_demux_pkg.sv
// Shared types and default sizing for the stream_demux block.
package stream_demux_pkg;

    // Occupancy of a single output slot
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int unsigned DEFAULT_WIDTH    = 32;
    localparam int unsigned DEFAULT_CHANNELS = 4;
    localparam int unsigned DEFAULT_CNT_W    = 16;

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice holding a single word for one output channel.
// The parent only asserts WR_EN when the slot is empty or being drained this cycle.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    input  logic             READY
);

    slot_state_e state;

    // Slot state and data: a write always wins over a drain, so drain+write stays FULL
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= EMPTY;
            DOUT  <= '0;
        end else if (WR_EN) begin
            state <= FULL;
            DOUT  <= DIN;
        end else if (state == FULL && READY) begin
            state <= EMPTY;
        end
    end

    assign VALID = (state == FULL);

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-CHANNELS stream demultiplexer with per-channel valid/ready.
// Selects that name a nonexistent channel are accepted, dropped and counted.
// Optional feature: define STREAM_DEMUX_BCAST_EN to add the BCAST input, which
// writes the word to every channel at once when all slots can take it.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned  WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned  CHANNELS = DEFAULT_CHANNELS,
    parameter int unsigned  CNT_W    = DEFAULT_CNT_W,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST,
`ifdef STREAM_DEMUX_BCAST_EN
    input  logic                      BCAST,
`endif
    input  logic [SEL_W-1:0]          SELECT,
    input  logic [WIDTH-1:0]          DATA_IN,
    input  logic                      VALID_IN,
    output logic                      READY_OUT,
    output logic [CHANNELS*WIDTH-1:0] DATA_OUT,
    output logic [CHANNELS-1:0]       VALID_OUT,
    input  logic [CHANNELS-1:0]       READY_IN,
    output logic                      ERR_SEL,
    output logic [CNT_W-1:0]          DROP_CNT
);

    logic                sel_invalid;
    logic [CHANNELS-1:0] sel_onehot;
    logic [CHANNELS-1:0] slot_free;
    logic [CHANNELS-1:0] wr_en;
    logic                uni_ready;
    logic                accept;
    logic                drop;

    // Widened compare keeps this meaningful (and constant-false) for power-of-2 counts
    assign sel_invalid = (32'(SELECT) >= CHANNELS);
    assign slot_free   = ~VALID_OUT | READY_IN;

    // Decode SELECT to a one-hot channel mask; empty for invalid selects
    always_comb begin
        sel_onehot = '0;
        if (!sel_invalid) begin
            sel_onehot[SELECT] = 1'b1;
        end
    end

    assign uni_ready = sel_invalid || |(sel_onehot & slot_free);

`ifdef STREAM_DEMUX_BCAST_EN
    assign READY_OUT = BCAST ? (&slot_free) : uni_ready;
    assign accept    = VALID_IN && READY_OUT;
    assign wr_en     = !accept ? '0 : (BCAST ? '1 : sel_onehot);
    assign drop      = accept && !BCAST && sel_invalid;
`else
    assign READY_OUT = uni_ready;
    assign accept    = VALID_IN && READY_OUT;
    assign wr_en     = accept ? sel_onehot : '0;
    assign drop      = accept && sel_invalid;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .CLK   (CLK),
            .RST   (RST),
            .WR_EN (wr_en[c]),
            .DIN   (DATA_IN),
            .DOUT  (DATA_OUT[c*WIDTH +: WIDTH]),
            .VALID (VALID_OUT[c]),
            .READY (READY_IN[c])
        );
    end

    // Drop accounting: one-cycle error pulse and a saturating drop counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR_SEL  <= 1'b0;
            DROP_CNT <= '0;
        end else begin
            ERR_SEL <= drop;
            if (drop && DROP_CNT != '1) begin
                DROP_CNT <= DROP_CNT + 1'b1;
            end
        end
    end

endmodule
